// File: rtl/nr_demux4_port.sv
// Registered 1-to-4 demultiplexer: steers one producer word into one of four
// independently drained holding registers, with a per-channel accept counter.
module nr_demux4_port #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [1:0]           in_sel,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 in_ready,
  output logic [3:0]           out_valid,
  output logic [4*WIDTH-1:0]   out_data,
  input  logic [3:0]           out_ready,
  output logic [4*CNT_W-1:0]   xfer_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} ch_state_t;

  ch_state_t        state_p0  [4];
  ch_state_t        state_nxt [4];
  logic [WIDTH-1:0] data_p0   [4];
  logic [CNT_W-1:0] cnt_p0    [4];
  logic [3:0]       vld_p0;
  logic             accept;
  logic [3:0]       acc_ch;

  // A full channel still accepts when its consumer drains in the same cycle.
  assign in_ready = !rst && (!vld_p0[in_sel] || out_ready[in_sel]);
  assign accept   = in_valid && in_ready;
  assign acc_ch   = accept ? (4'b0001 << in_sel) : 4'b0000;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      state_nxt[i] = state_p0[i];
      case (state_p0[i])
        EMPTY:   if (acc_ch[i]) state_nxt[i] = FULL;
        FULL:    if (!acc_ch[i] && out_ready[i]) state_nxt[i] = EMPTY;
        default: state_nxt[i] = EMPTY;
      endcase
    end
  end

  // p0: holding registers and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        state_p0[i] <= EMPTY;
        data_p0[i]  <= '0;
        cnt_p0[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_p0[i] <= state_nxt[i];
        if (acc_ch[i]) begin
          data_p0[i] <= in_data;
          cnt_p0[i]  <= cnt_p0[i] + CNT_W'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_out
    assign vld_p0[g]                      = (state_p0[g] == FULL);
    assign out_valid[g]                   = vld_p0[g];
    assign out_data[g*WIDTH +: WIDTH]     = data_p0[g];
    assign xfer_cnt[g*CNT_W +: CNT_W]     = cnt_p0[g];
  end

endmodule

// File: tb/tb_nr_demux4_port.sv
// Bench for nr_demux4_port: directed vectors plus a per-channel array model
// checked against the DUT on every falling edge.
module tb_nr_demux4_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [1:0]  in_sel;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [3:0]  out_valid;
  logic [31:0] out_data;
  logic [3:0]  out_ready;
  logic [31:0] xfer_cnt;

  int errs   = 0;
  int checks = 0;

  nr_demux4_port #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sel(in_sel),
    .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: one flag, one word and one count per channel.
  logic       m_vld  [4];
  logic [7:0] m_data [4];
  logic [7:0] m_cnt  [4];

  function automatic bit model_rdy();
    return !rst && (!m_vld[in_sel] || out_ready[in_sel]);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_vld[i]  <= 1'b0;
        m_data[i] <= 8'h00;
        m_cnt[i]  <= 8'h00;
      end
    end else begin
      for (int i = 0; i < 4; i++)
        if (m_vld[i] && out_ready[i]) m_vld[i] <= 1'b0;
      if (in_valid && model_rdy()) begin
        m_vld[in_sel]  <= 1'b1;
        m_data[in_sel] <= in_data;
        m_cnt[in_sel]  <= m_cnt[in_sel] + 8'd1;
      end
    end
  end

  function automatic logic [31:0] pack_data();
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = m_data[i];
    return r;
  endfunction

  function automatic logic [31:0] pack_cnt();
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = m_cnt[i];
    return r;
  endfunction

  function automatic logic [3:0] pack_vld();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = m_vld[i];
    return r;
  endfunction

  always @(negedge clk) begin
    chk("model_in_ready",  {31'd0, in_ready}, {31'd0, model_rdy()});
    chk("model_out_valid", {28'd0, out_valid}, {28'd0, pack_vld()});
    chk("model_out_data",  out_data, pack_data());
    chk("model_xfer_cnt",  xfer_cnt, pack_cnt());
  end

  // Consumer-3 log for the streaming test.
  logic       cap_en = 1'b0;
  logic [7:0] cap [$];

  always @(negedge clk)
    if (cap_en && out_valid[3] && out_ready[3]) cap.push_back(out_data[31:24]);

  task automatic send(input logic [1:0] sel, input logic [7:0] d);
    bit acc = 0;
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = d;
    #1;
    for (int c = 0; c < 50; c++) begin
      if (in_ready) begin
        @(posedge clk); #1;
        acc = 1;
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = 8'h00; out_ready = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    chk("init_in_ready_rst", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("init_out_valid", {28'd0, out_valid}, 32'd0);
    chk("init_out_data",  out_data, 32'd0);
    chk("init_xfer_cnt",  xfer_cnt, 32'd0);

    // Asynchronous reset with channel 2 holding 0xA5
    send(2'd2, 8'hA5);
    chk("pre_rst_ch2", {24'd0, out_data[23:16]}, 32'hA5);
    in_valid = 1'b1; in_sel = 2'd2; in_data = 8'h5A;
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", {28'd0, out_valid}, 32'd0);
    chk("rst_out_data",  out_data, 32'd0);
    chk("rst_xfer_cnt",  xfer_cnt, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;

    // Basic routing
    for (int i = 0; i < 4; i++) send(2'(i), 8'(11 + i));
    chk("route_valid", {28'd0, out_valid}, 32'h0000000F);
    chk("route_data",  out_data, 32'h0E0D0C0B);
    chk("route_cnt",   xfer_cnt, 32'h01010101);

    // Backpressure on channel 1
    in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h3C;
    repeat (5) begin
      #1;
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_ch1_hold", {24'd0, out_data[15:8]}, 32'd12);
      @(posedge clk); #1;
    end
    out_ready = 4'b0010;
    #1;
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 4'b0000;
    chk("bp_ch1_data",  {24'd0, out_data[15:8]}, 32'h3C);
    chk("bp_ch1_valid", {31'd0, out_valid[1]}, 32'd1);
    chk("bp_ch1_cnt",   {24'd0, xfer_cnt[15:8]}, 32'd2);

    // Independence: ch0 stalled full, ch2 emptied then written
    out_ready = 4'b0100;
    @(posedge clk); #1;
    out_ready = 4'b0000;
    chk("ind_drained", {28'd0, out_valid}, 32'h0000000B);
    in_valid = 1'b1; in_sel = 2'd2; in_data = 8'h77;
    #1;
    chk("ind_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("ind_data",  out_data, 32'h0E773C0B);
    chk("ind_valid", {28'd0, out_valid}, 32'h0000000F);
    chk("ind_cnt",   xfer_cnt, 32'h01020201);

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Streaming 0..19 into channel 3
    out_ready = 4'b1000; cap_en = 1'b1;
    in_valid = 1'b1; in_sel = 2'd3;
    for (int k = 0; k < 20; k++) begin
      in_data = 8'(k);
      #1;
      chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    cap_en = 1'b0; out_ready = 4'b0000;
    chk("stream_count", cap.size(), 32'd20);
    for (int k = 0; k < cap.size() && k < 20; k++)
      chk("stream_word", {24'd0, cap[k]}, 32'(k));
    chk("stream_cnt",   xfer_cnt, 32'h14000000);
    chk("stream_empty", {28'd0, out_valid}, 32'd0);

    // Counter wrap on channel 0
    out_ready = 4'b0001; in_valid = 1'b1; in_sel = 2'd0;
    for (int n = 1; n <= 256; n++) begin
      in_data = 8'(n);
      @(posedge clk); #1;
      if (n == 255) chk("wrap_255", {24'd0, xfer_cnt[7:0]}, 32'd255);
      if (n == 256) chk("wrap_0",   {24'd0, xfer_cnt[7:0]}, 32'd0);
    end
    in_valid = 1'b0;
    chk("wrap_others", {8'd0, xfer_cnt[31:8]}, 32'h00140000);
    @(posedge clk); #1;
    out_ready = 4'b0000;
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
